sead_scrubber: RTL and testbench

- Background ECC scrubber for SEAD-protected 32-bit storage, i.e. register file or data memory entries that hold 32 data bits plus 15 parity bits (3 chunks × 5-bit SEC-DED).
- This is the read/repair end of the protection scheme. Stored words are read back, interleaved, decoded per 11-bit chunk and deinterleaved. A word found with a correctable error is re-encoded and written back before a second upset can turn it into an uncorrectable double error.
- Shares a single storage port with the core through a req/gnt handshake. The core always has priority.

---
 rtl/sead_scrubber.sv | 237 +++++++++++++++++++++++
 tb/tb_sead_scrubber.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sead_scrubber.sv
// Background scrubber for SEAD-protected 32-bit words (3 x 11-bit SEC-DED chunks).
// Reads each entry, decodes it and writes back a re-encoded word when a single
// correctable error is found; double errors are counted and flagged only.
// Handshake: a storage transfer happens in every cycle where mem_req && mem_gnt;
// mem_req, mem_we and mem_addr stay stable until that cycle, and read data
// arrives with mem_rvalid exactly one cycle after a granted read.
module sead_scrubber #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              enable,
  input  logic              scrub_now,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [14:0]       mem_wparity,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic [14:0]       mem_rparity,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_wr_addr,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic              uncorr_irq,
  output logic              pass_done,
  output logic              busy
);

  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_ENC, S_WR_REQ, S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [IW-1:0]     icnt_q;
  logic              sweep_q;
  logic              stale_q;
  logic [31:0]       raw_data_q;
  logic [14:0]       raw_par_q;
  logic [31:0]       corr_q;
  logic [31:0]       iv_raw, iv_corr, corr_data;
  logic [14:0]       regen_par;
  logic              dbl, single, wrap, stale_hit;

  // Hamming check bits {p8,p4,p2,p1}; data bits sit at positions 3,5,6,7,9..15.
  function automatic logic [3:0] chk4(input logic [10:0] d);
    return {^(d & 11'b11111110000), ^(d & 11'b11110001110),
            ^(d & 11'b11001101101), ^(d & 11'b10101011011)};
  endfunction

  // 5 parity bits of one chunk: {overall, p8, p4, p2, p1}.
  function automatic logic [4:0] enc5(input logic [10:0] d);
    logic [3:0] c;
    c = chk4(d);
    return {^d ^ ^c, c};
  endfunction

  // Data bit i goes to chunk i%3, slot i/3, so a burst hits different chunks.
  function automatic logic [31:0] ilv(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[(i % 3) * 11 + i / 3] = d[i];
    return r;
  endfunction

  function automatic logic [31:0] dilv(input logic [31:0] iv);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = iv[(i % 3) * 11 + i / 3];
    return r;
  endfunction

  // Full 15-bit parity of a data word; chunk 3 carries a constant-zero pad bit.
  function automatic logic [14:0] enc_word(input logic [31:0] d);
    logic [31:0] iv;
    iv = ilv(d);
    return {enc5({1'b0, iv[31:22]}), enc5(iv[21:11]), enc5(iv[10:0])};
  endfunction

  // Nonzero syndrome with even overall parity means two flipped bits.
  function automatic logic dbl11(input logic [10:0] d, input logic [4:0] p);
    return ((chk4(d) ^ p[3:0]) != 4'd0) && !(^{d, p});
  endfunction

  // Data flip mask for a single error; parity-bit errors need no data flip.
  function automatic logic [10:0] flip11(input logic [10:0] d, input logic [4:0] p);
    logic [3:0]  syn;
    logic [10:0] fm;
    syn = chk4(d) ^ p[3:0];
    fm  = '0;
    if (^{d, p}) begin
      case (syn)
        4'd3:  fm[0]  = 1'b1;
        4'd5:  fm[1]  = 1'b1;
        4'd6:  fm[2]  = 1'b1;
        4'd7:  fm[3]  = 1'b1;
        4'd9:  fm[4]  = 1'b1;
        4'd10: fm[5]  = 1'b1;
        4'd11: fm[6]  = 1'b1;
        4'd12: fm[7]  = 1'b1;
        4'd13: fm[8]  = 1'b1;
        4'd14: fm[9]  = 1'b1;
        4'd15: fm[10] = 1'b1;
        default: fm = '0;
      endcase
    end
    return fm;
  endfunction

  // Decode the captured word: correct each chunk, drop chunk 3's pad, classify.
  always_comb begin
    iv_raw  = ilv(raw_data_q);
    iv_corr = {iv_raw[31:22] ^ 10'(flip11({1'b0, iv_raw[31:22]}, raw_par_q[14:10])),
               iv_raw[21:11] ^ flip11(iv_raw[21:11], raw_par_q[9:5]),
               iv_raw[10:0]  ^ flip11(iv_raw[10:0], raw_par_q[4:0])};
    corr_data = dilv(iv_corr);
    regen_par = enc_word(corr_data);
    dbl       = dbl11(iv_raw[10:0], raw_par_q[4:0])
              | dbl11(iv_raw[21:11], raw_par_q[9:5])
              | dbl11({1'b0, iv_raw[31:22]}, raw_par_q[14:10]);
    single    = !dbl && ((corr_data != raw_data_q) || (regen_par != raw_par_q));
  end

  assign wrap       = (addr_q == ADDR_W'(DEPTH - 1));
  assign mem_addr   = addr_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_WAIT);
  assign uncorr_irq = (state_q == S_CHECK) && dbl;
  assign pass_done  = (state_q == S_NEXT) && wrap;

  // A core write to the entry in flight makes the pending write-back stale.
  assign stale_hit = core_wr && (core_wr_addr == addr_q) &&
                     (((state_q == S_RD_REQ) && mem_gnt) || (state_q == S_RD_WAIT) ||
                      (state_q == S_CHECK) || (state_q == S_ENC) ||
                      ((state_q == S_WR_REQ) && !mem_gnt));

  // Next-state and storage request decode.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scrub_now)   state_d = S_RD_REQ;
        else if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (scrub_now)           state_d = S_RD_REQ;
        else if (!enable)        state_d = S_IDLE;
        else if (icnt_q == '0)   state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rvalid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!dbl && single) state_d = S_ENC;
        else                state_d = S_NEXT;
      end
      S_ENC: state_d = S_WR_REQ;
      S_WR_REQ: begin
        if (stale_q) begin
          state_d = S_NEXT;
        end else begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (mem_gnt) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (sweep_q && !wrap) state_d = S_RD_REQ;
        else if (enable)      state_d = S_WAIT;
        else                  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and statistics registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      icnt_q        <= '0;
      sweep_q       <= 1'b0;
      stale_q       <= 1'b0;
      raw_data_q    <= '0;
      raw_par_q     <= '0;
      corr_q        <= '0;
      mem_wdata     <= '0;
      mem_wparity   <= '0;
      corr_count    <= '0;
      uncorr_count  <= '0;
      last_err_addr <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == S_WAIT) && (state_q != S_WAIT)) icnt_q <= IW'(INTERVAL - 1);
      else if ((state_q == S_WAIT) && (icnt_q != '0))  icnt_q <= icnt_q - 1'b1;
      if (((state_q == S_IDLE) || (state_q == S_WAIT)) && scrub_now) sweep_q <= 1'b1;
      else if ((state_q == S_NEXT) && wrap)                          sweep_q <= 1'b0;
      if ((state_q == S_RD_WAIT) && mem_rvalid) begin
        raw_data_q <= mem_rdata;
        raw_par_q  <= mem_rparity;
      end
      if (state_q == S_CHECK) begin
        corr_q <= corr_data;
        if (dbl) begin
          if (uncorr_count != {CNT_W{1'b1}}) uncorr_count <= uncorr_count + 1'b1;
          last_err_addr <= addr_q;
        end else if (single) begin
          if (corr_count != {CNT_W{1'b1}}) corr_count <= corr_count + 1'b1;
          last_err_addr <= addr_q;
        end
      end
      if (state_q == S_ENC) begin
        mem_wdata   <= corr_q;
        mem_wparity <= enc_word(corr_q);
      end
      if (state_q == S_NEXT) begin
        addr_q  <= wrap ? '0 : addr_q + 1'b1;
        stale_q <= 1'b0;
      end else if (stale_hit) begin
        stale_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sead_scrubber.sv
// Bench for sead_scrubber: storage model with grant control, access scoreboard,
// error-injection table and hand-written sweep / stale / reset sequences.
module tb_sead_scrubber;

  localparam int W = 53;  // {we, addr[4:0], data[31:0], parity[14:0]}

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        enable = 1'b0;
  logic        scrub_now = 1'b0;
  logic        mem_req, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [14:0] mem_wparity;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [14:0] mem_rparity = '0;
  logic        core_wr = 1'b0;
  logic [4:0]  core_wr_addr = '0;
  logic [15:0] corr_count, uncorr_count;
  logic [4:0]  last_err_addr;
  logic        uncorr_irq, pass_done, busy;

  sead_scrubber #(.DEPTH(32), .ADDR_W(5), .INTERVAL(4), .CNT_W(16)) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .scrub_now(scrub_now),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wparity(mem_wparity), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rparity(mem_rparity),
    .core_wr(core_wr), .core_wr_addr(core_wr_addr),
    .corr_count(corr_count), .uncorr_count(uncorr_count),
    .last_err_addr(last_err_addr), .uncorr_irq(uncorr_irq),
    .pass_done(pass_done), .busy(busy)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] md [32];
  logic [14:0] mp [32];
  logic [31:0] od [32];
  int          rd_cyc [32];
  int          cyc = 0;
  int          pd_cnt = 0, irq_cnt = 0;
  logic [4:0]  irq_addr = '0;
  logic        rd_pend = 1'b0;
  logic [4:0]  rd_a = '0;
  int          blk_cnt = 0;
  logic [4:0]  blk_core_addr = '0;
  logic        core_done = 1'b0;
  logic        hold_en = 1'b0;
  logic [4:0]  hold_addr = '0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] fd;
    logic [14:0] fp;
    logic        exp_wr;
    logic        exp_dbl;
  } vec_t;
  vec_t vt [7];

  // Reference parity: chunk c holds data bits d[3k+c]; the Hamming check value
  // is the XOR of the codeword positions of all set data bits.
  function automatic logic [14:0] tb_par(input logic [31:0] d);
    logic [14:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      logic [3:0] chk;
      logic       ov;
      int         k;
      chk = '0;
      ov  = 1'b0;
      k   = 0;
      for (int pos = 1; pos < 16; pos++) begin
        if ((pos & (pos - 1)) != 0) begin
          if (3 * k + c < 32) begin
            if (d[3 * k + c]) begin
              chk ^= 4'(pos);
              ov  ^= 1'b1;
            end
          end
          k++;
        end
      end
      ov = ov ^ (^chk);
      r[c * 5 +: 5] = {ov, chk};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rec(input logic we, input logic [4:0] a,
                                       input logic [31:0] d, input logic [14:0] p);
    return {we, a, d, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: compare every granted access against the expected queue
  always @(negedge clk) begin
    logic [W-1:0] act;
    cyc++;
    if (rstN) begin
      if (pass_done) pd_cnt++;
      if (uncorr_irq) begin
        irq_cnt++;
        irq_addr = mem_addr;
      end
      if (mem_req && mem_gnt) begin
        act = rec(mem_we, mem_addr, mem_we ? mem_wdata : 32'h0, mem_we ? mem_wparity : 15'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL access: got %0h expected none", act);
        end else begin
          check("access", act, exp_q.pop_front());
        end
        if (mem_we) begin
          md[mem_addr] = mem_wdata;
          mp[mem_addr] = mem_wparity;
        end else begin
          rd_pend = 1'b1;
          rd_a    = mem_addr;
          rd_cyc[mem_addr] = cyc;
        end
      end
    end
  end

  // storage model: read return, grant throttling and core writes
  always @(posedge clk) begin
    #1;
    mem_rvalid = rd_pend;
    if (rd_pend) begin
      mem_rdata   = md[rd_a];
      mem_rparity = mp[rd_a];
    end
    rd_pend = 1'b0;
    mem_gnt = 1'b1;
    core_wr = 1'b0;
    if (hold_en && mem_req && !mem_we && mem_addr == hold_addr) mem_gnt = 1'b0;
    if (blk_cnt > 0 && mem_req && mem_we) begin
      mem_gnt = 1'b0;
      blk_cnt--;
      if (blk_cnt == 3) begin
        core_wr      = 1'b1;
        core_wr_addr = blk_core_addr;
        md[blk_core_addr] = $urandom;
        mp[blk_core_addr] = tb_par(md[blk_core_addr]);
        core_done = 1'b1;
        blk_cnt   = 0;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #2;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstN = 1'b1;
  endtask

  task automatic pulse_scrub();
    @(posedge clk); #2 scrub_now = 1'b1;
    @(posedge clk); #2 scrub_now = 1'b0;
  endtask

  task automatic fill_clean();
    for (int a = 0; a < 32; a++) begin
      md[a] = $urandom;
      mp[a] = tb_par(md[a]);
      od[a] = md[a];
    end
  endtask

  initial begin
    int exp_corr, exp_unc;
    logic [4:0] exp_last;

    fill_clean();
    do_reset();
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wparity", mem_wparity, 0);
    check("rst_corr", corr_count, 0);
    check("rst_uncorr", uncorr_count, 0);
    check("rst_last_err", last_err_addr, 0);
    check("rst_irq", uncorr_irq, 0);
    check("rst_pass_done", pass_done, 0);
    check("rst_busy", busy, 0);

    // ---- pass 1: background scrub with an injection table ----
    vt[0] = '{5'd5,  32'h0000_2000, 15'h0000, 1'b1, 1'b0};  // data bit 13
    vt[1] = '{5'd7,  32'h0000_0000, 15'h0004, 1'b1, 1'b0};  // parity bit 2 only
    vt[2] = '{5'd9,  32'h0000_0009, 15'h0000, 1'b0, 1'b1};  // two bits, chunk 1
    vt[3] = '{5'd12, 32'h8000_0000, 15'h0000, 1'b1, 1'b0};  // data bit 31
    vt[4] = '{5'd20, 32'h0000_0000, 15'h4000, 1'b1, 1'b0};  // chunk 3 overall parity
    vt[5] = '{5'd25, 32'h0000_0003, 15'h0000, 1'b1, 1'b0};  // one bit in each of two chunks
    vt[6] = '{5'd31, 32'h0000_0024, 15'h0000, 1'b0, 1'b1};  // two bits, chunk 3, last entry
    exp_corr = 0;
    exp_unc  = 0;
    exp_last = '0;
    for (int i = 0; i < 7; i++) begin
      md[vt[i].addr] ^= vt[i].fd;
      mp[vt[i].addr] ^= vt[i].fp;
      exp_corr += int'(vt[i].exp_wr);
      exp_unc  += int'(vt[i].exp_dbl);
      exp_last = vt[i].addr;
    end
    for (int a = 0; a < 32; a++) begin
      exp_q.push_back(rec(1'b0, 5'(a), 32'h0, 15'h0));
      for (int i = 0; i < 7; i++)
        if (vt[i].addr == 5'(a) && vt[i].exp_wr)
          exp_q.push_back(rec(1'b1, 5'(a), od[a], tb_par(od[a])));
    end
    pd_cnt = 0;
    irq_cnt = 0;
    @(posedge clk); #2 enable = 1'b1;
    for (int i = 0; i < 3000 && pd_cnt == 0; i++) @(negedge clk);
    @(posedge clk); #2 enable = 1'b0;
    repeat (12) @(negedge clk);
    check("p1_pass_done", pd_cnt, 1);
    check("p1_queue_left", exp_q.size(), 0);
    check("p1_corr", corr_count, exp_corr);
    check("p1_uncorr", uncorr_count, exp_unc);
    check("p1_last_err", last_err_addr, exp_last);
    check("p1_irq_pulses", irq_cnt, exp_unc);
    check("p1_irq_last_addr", irq_addr, 31);
    check("p1_read_gap", rd_cyc[2] - rd_cyc[1], 8);
    check("p1_idle", busy, 0);
    for (int i = 0; i < 7; i++) begin
      if (vt[i].exp_wr) begin
        check("p1_fixed_data", md[vt[i].addr], od[vt[i].addr]);
        check("p1_fixed_par", mp[vt[i].addr], tb_par(od[vt[i].addr]));
      end else begin
        check("p1_dbl_untouched", md[vt[i].addr], od[vt[i].addr] ^ vt[i].fd);
      end
    end

    // ---- pass 2: scrub_now sweep, stalled write-back cancelled by core write ----
    do_reset();
    fill_clean();
    md[3] ^= 32'h0010_0000;
    for (int a = 0; a < 32; a++) exp_q.push_back(rec(1'b0, 5'(a), 32'h0, 15'h0));
    blk_core_addr = 5'd3;
    blk_cnt   = 6;
    core_done = 1'b0;
    pd_cnt = 0;
    irq_cnt = 0;
    pulse_scrub();
    for (int i = 0; i < 1000 && pd_cnt == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("p2_pass_done", pd_cnt, 1);
    check("p2_queue_left", exp_q.size(), 0);
    check("p2_wr_req_seen", core_done, 1);
    check("p2_corr", corr_count, 1);
    check("p2_uncorr", uncorr_count, 0);
    check("p2_last_err", last_err_addr, 3);
    check("p2_irq", irq_cnt, 0);
    check("p2_read_gap", rd_cyc[2] - rd_cyc[1], 4);
    check("p2_idle", busy, 0);
    check("p2_no_req", mem_req, 0);

    // ---- pass 3: reset while a read request is held ungranted ----
    hold_addr = 5'd5;
    hold_en   = 1'b1;
    for (int a = 0; a < 5; a++) exp_q.push_back(rec(1'b0, 5'(a), 32'h0, 15'h0));
    pulse_scrub();
    for (int i = 0; i < 300 && !(mem_req && mem_addr == 5'd5); i++) @(negedge clk);
    check("p3_hold_reached", mem_req && mem_addr == 5'd5, 1);
    repeat (3) @(negedge clk);
    check("p3_req_held", mem_req, 1);
    check("p3_addr_held", mem_addr, 5);
    #2 rstN = 1'b0;
    #1;
    check("p3_async_req", mem_req, 0);
    check("p3_async_addr", mem_addr, 0);
    check("p3_async_busy", busy, 0);
    hold_en = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    repeat (10) @(negedge clk);
    check("p3_queue_left", exp_q.size(), 0);
    check("p3_no_req", mem_req, 0);
    check("p3_corr", corr_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
